// File: rtl/video_timing_rx.sv
// Recovers per-pixel coordinates from a de/hs/vs/rgb stream, measures line and
// frame geometry, and reports lock once that geometry repeats frame after frame.
module video_timing_rx #(
    parameter logic        HS_POL         = 1'b1,
    parameter logic        VS_POL         = 1'b1,
    parameter int unsigned LOCK_FRAMES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        de,
    input  logic        hs,
    input  logic        vs,
    input  logic [2:0]  rgb,
    output logic        pixel_valid,
    output logic [2:0]  pixel_data,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] h_total,
    output logic [15:0] h_active,
    output logic [15:0] v_total,
    output logic [15:0] v_active,
    output logic        locked
);
    localparam int unsigned CW = 10;
    localparam int unsigned MW = 16;
    localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NW = 4;
    localparam logic [CW-1:0] C_MAX = '1;
    localparam logic [MW-1:0] M_MAX = '1;
    localparam logic [SW-1:0] S_LIM = SW'(TIMEOUT_CYCLES);
    localparam logic [NW-1:0] N_LIM = NW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
        return (v == M_MAX) ? v : v + MW'(1);
    endfunction

    // previous input values used for edge detection
    logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    // pixel outputs
    logic          pixel_valid_q, pixel_valid_d;
    logic [2:0]    pixel_data_q, pixel_data_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d, ycnt_q, ycnt_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          seen_vs_q, seen_vs_d;
    // geometry measurement
    logic [MW-1:0] hcnt_q, hcnt_d, h_total_q, h_total_d;
    logic [MW-1:0] hact_q, hact_d, h_active_q, h_active_d;
    logic [MW-1:0] vcnt_q, vcnt_d, v_total_q, v_total_d;
    logic [MW-1:0] vact_q, vact_d, v_active_q, v_active_d;
    logic [SW-1:0] sil_q, sil_d;
    // lock tracking
    state_t          state_q, state_d;
    logic [NW-1:0]   match_q, match_d;
    logic            first_q, first_d;
    logic [4*MW-1:0] ref_q, ref_d;
    logic            locked_q, locked_d;

    logic            hs_edge, vs_edge, de_rise, de_fall, timeout;
    logic [4*MW-1:0] meas_set;

    // edges against the previous registered input values
    assign hs_edge = (hs == HS_POL) && (hs_q != HS_POL);
    assign vs_edge = (vs == VS_POL) && (vs_q != VS_POL);
    assign de_rise = de && !de_q;
    assign de_fall = !de && de_q;

    // next-state for pixel tracking, measurement counters and lock FSM
    always_comb begin
        de_d          = de;
        hs_d          = hs;
        vs_d          = vs;
        pixel_valid_d = de;
        pixel_data_d  = de ? rgb : 3'd0;
        x_d           = '0;
        ycnt_d        = ycnt_q;
        seen_vs_d     = seen_vs_q | vs_edge;
        hcnt_d        = hs_edge ? MW'(1) : sat_inc(hcnt_q);
        h_total_d     = h_total_q;
        hact_d        = hact_q;
        h_active_d    = h_active_q;
        vcnt_d        = hs_edge ? sat_inc(vcnt_q) : vcnt_q;
        v_total_d     = v_total_q;
        vact_d        = de_fall ? sat_inc(vact_q) : vact_q;
        v_active_d    = v_active_q;
        sil_d         = hs_edge ? '0 : ((sil_q == S_LIM) ? sil_q : sil_q + SW'(1));
        state_d       = state_q;
        match_d       = match_q;
        first_d       = first_q;
        ref_d         = ref_q;

        // line index: vs clears, a finished line advances (vs wins)
        if (vs_edge) begin
            ycnt_d = '0;
        end else if (de_fall && (ycnt_q != C_MAX)) begin
            ycnt_d = ycnt_q + CW'(1);
        end
        if (de) begin
            x_d = de_rise ? '0 : ((x_q == C_MAX) ? x_q : x_q + CW'(1));
        end
        y_d           = de ? ycnt_d : '0;
        line_start_d  = de_rise;
        frame_start_d = de_rise && (ycnt_d == '0) && seen_vs_d;

        if (hs_edge) begin
            h_total_d = hcnt_q;
        end
        if (de) begin
            hact_d = de_rise ? MW'(1) : sat_inc(hact_q);
        end
        if (de_fall) begin
            h_active_d = hact_q;
        end
        // a coincident hs/de event is counted in the frame that is ending
        if (vs_edge) begin
            v_total_d  = vcnt_d;
            v_active_d = vact_d;
            vcnt_d     = '0;
            vact_d     = '0;
        end

        meas_set = {h_total_d, h_active_d, v_total_d, v_active_d};
        timeout  = (sil_d == S_LIM);
        if (vs_edge) begin
            ref_d = meas_set;
        end

        case (state_q)
            IDLE: begin
                if (vs_edge) begin
                    state_d = MEASURE;
                    match_d = '0;
                    first_d = 1'b1;
                end
            end
            MEASURE: begin
                if (vs_edge) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        match_d = NW'(1);
                    end else if (meas_set == ref_q) begin
                        match_d = match_q + NW'(1);
                    end else begin
                        match_d = '0;
                    end
                    if (match_d >= N_LIM) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (vs_edge && (meas_set != ref_q)) begin
                    state_d = MEASURE;
                    match_d = '0;
                    first_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = IDLE;
            match_d = '0;
            first_d = 1'b0;
        end
        locked_d = (state_d == LOCKED);
    end

    // state registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ycnt_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            seen_vs_q     <= 1'b0;
            hcnt_q        <= '0;
            h_total_q     <= '0;
            hact_q        <= '0;
            h_active_q    <= '0;
            vcnt_q        <= '0;
            v_total_q     <= '0;
            vact_q        <= '0;
            v_active_q    <= '0;
            sil_q         <= '0;
            state_q       <= IDLE;
            match_q       <= '0;
            first_q       <= 1'b0;
            ref_q         <= '0;
            locked_q      <= 1'b0;
        end else begin
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ycnt_q        <= ycnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            seen_vs_q     <= seen_vs_d;
            hcnt_q        <= hcnt_d;
            h_total_q     <= h_total_d;
            hact_q        <= hact_d;
            h_active_q    <= h_active_d;
            vcnt_q        <= vcnt_d;
            v_total_q     <= v_total_d;
            vact_q        <= vact_d;
            v_active_q    <= v_active_d;
            sil_q         <= sil_d;
            state_q       <= state_d;
            match_q       <= match_d;
            first_q       <= first_d;
            ref_q         <= ref_d;
            locked_q      <= locked_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_data  = pixel_data_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_total     = h_total_q;
    assign h_active    = h_active_q;
    assign v_total     = v_total_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// Bench for video_timing_rx: synthetic video frames with a per-pixel scoreboard
// plus directed lock/measurement checks at vs edges.
module tb_video_timing_rx;
    logic        clk_in;
    logic        rst_n;
    logic        de, hs, vs;
    logic [2:0]  rgb;
    logic        pixel_valid;
    logic [2:0]  pixel_data;
    logic [9:0]  x, y;
    logic        line_start, frame_start;
    logic [15:0] h_total, h_active, v_total, v_active;
    logic        locked;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
    } geom_t;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [25:0] sb_q[$];
    bit          seen_vs;

    video_timing_rx dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .de          (de),
        .hs          (hs),
        .vs          (vs),
        .rgb         (rgb),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .h_total     (h_total),
        .h_active    (h_active),
        .v_total     (v_total),
        .v_active    (v_active),
        .locked      (locked)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [25:0] obs_pix();
        return {pixel_valid, pixel_data, x, y, line_start, frame_start};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one input cycle, queue its expected pixel result, compare after the edge
    task automatic step(input logic d, input logic h, input logic v,
                        input logic [2:0] c, input logic [25:0] e);
        logic [25:0] exp_pix;
        de = d; hs = h; vs = v; rgb = c;
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        exp_pix = sb_q.pop_front();
        chk("pix", 64'(obs_pix()), 64'(exp_pix));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 26'd0);
    endtask

    // one frame starting at line 0 pixel 0; vs asserts together with the hs of line va+vfp
    task automatic drive_frame(input geom_t g, input int hx, input bit lk_pre,
                               input bit lk_post, input bit chk_meas);
        int htot, vtot, hs0, von, voff, p;
        logic d, h, v;
        logic [2:0] c;
        logic [9:0] xs;
        logic [25:0] e;
        htot = g.ha + g.hfp + g.hsw + g.hbp + hx;
        vtot = g.va + g.vfp + g.vsw + g.vbp;
        hs0  = g.ha + g.hfp;
        von  = (g.va + g.vfp) * htot + hs0;
        voff = (g.va + g.vfp + g.vsw) * htot + hs0;
        for (int ln = 0; ln < vtot; ln++) begin
            for (int px = 0; px < htot; px++) begin
                p  = ln * htot + px;
                d  = (ln < g.va) && (px < g.ha);
                h  = (px >= hs0) && (px < hs0 + g.hsw);
                v  = (p >= von) && (p < voff);
                c  = 3'($urandom_range(7));
                xs = (px > 1023) ? 10'd1023 : 10'(px);
                e  = {d, d ? c : 3'd0, d ? xs : 10'd0, d ? 10'(ln) : 10'd0,
                      d && (px == 0), d && (px == 0) && (ln == 0) && seen_vs};
                if (p == von) chk("lock_pre", 64'(locked), 64'(lk_pre));
                step(d, h, v, c, e);
                if (v) seen_vs = 1'b1;
                if (p == von) begin
                    chk("lock_post", 64'(locked), 64'(lk_post));
                    if (chk_meas) begin
                        chk("h_total", 64'(h_total), 64'(htot));
                        chk("h_active", 64'(h_active), 64'(g.ha));
                        chk("v_total", 64'(v_total), 64'(vtot));
                        chk("v_active", 64'(v_active), 64'(g.va));
                    end
                end
            end
        end
    endtask

    initial begin
        geom_t g1, g2, g3;
        logic [2:0] c;
        g1 = '{800, 56, 120, 64, 4, 1, 1, 2};
        g2 = '{40, 4, 8, 4, 6, 2, 2, 2};
        g3 = '{1100, 4, 8, 4, 2, 1, 1, 1};
        rst_n = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = 3'd0; seen_vs = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_pix", 64'(obs_pix()), 64'd0);
        chk("rst_meas", {h_total, h_active, v_total, v_active}, 64'd0);
        chk("rst_lock", 64'(locked), 64'd0);
        rst_n = 1'b1;

        // 800-wide lines: lock on the 4th vs edge after reset
        drive_frame(g1, 0, 1'b0, 1'b0, 1'b0);
        drive_frame(g1, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g1, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g1, 0, 1'b0, 1'b1, 1'b1);

        // reset in the middle of an active line
        for (int px = 0; px < 300; px++) begin
            c = 3'($urandom_range(7));
            step(1'b1, 1'b0, 1'b0, c, {1'b1, c, 10'(px), 10'd0, px == 0, px == 0});
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pix", 64'(obs_pix()), 64'd0);
        chk("async_rst_meas", {h_total, h_active, v_total, v_active}, 64'd0);
        chk("async_rst_lock", 64'(locked), 64'd0);
        sb_q.delete();
        de = 1'b0; seen_vs = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;

        // small geometry: relock, one long-line frame, relock after 3 matches
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b0);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b1, 1'b1);
        drive_frame(g2, 1, 1'b1, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b1, 1'b1);

        // hs silence drops lock but keeps measurements
        idle(3000);
        chk("lock_hold", 64'(locked), 64'd1);
        idle(1300);
        chk("lock_timeout", 64'(locked), 64'd0);
        chk("meas_kept", {h_total, h_active, v_total, v_active},
            {16'd56, 16'd40, 16'd12, 16'd6});
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b0);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b0, 1'b1);
        drive_frame(g2, 0, 1'b0, 1'b1, 1'b1);

        // 1100-clock de: x saturates, geometry change drops lock
        drive_frame(g3, 0, 1'b1, 1'b0, 1'b0);
        drive_frame(g3, 0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
